// File: rtl/pic_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pic_load_ctrl
// Brief    : Job sequencer ahead of the pattern-to-index/compressed converter.
//            Clears the converter, streams K kernel words from weight memory
//            through a 2-entry buffer and tracks per-position slot overflow.
//            Optional abort/aborted port pair: define PIC_LOAD_ABORT_EN.
// Revision : 1.0  initial release
// ============================================================================
module pic_load_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 10,
  parameter int S          = 3,
  parameter int KH         = 3,
  parameter int KW         = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_b,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
`ifdef PIC_LOAD_ABORT_EN
  input  logic                             abort,
  output logic                             aborted,
`endif
  output logic                             busy,
  output logic                             done,
  output logic                             conv_clr,
  output logic                             rd_en,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [KH*KW*DATA_WIDTH-1:0]      rd_data,
  output logic                             w_valid,
  input  logic                             w_ready,
  output logic [KH*KW*DATA_WIDTH-1:0]      w_data,
  output logic [7:0]                       w_kidx,
  output logic                             w_last,
  output logic                             ovf,
  output logic [KH*KW-1:0]                 ovf_mask
);

  localparam int         NPOS = KH * KW;
  localparam int         WW   = NPOS * DATA_WIDTH;
  localparam int         CW   = (S < 1) ? 1 : $clog2(S + 1);
  localparam logic [7:0] KL   = 8'(K);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [7:0]            r_n;
  logic [7:0]            r_kidx;
  logic                  r_inflight;
  logic [WW-1:0]         r_fifo [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic [CW-1:0]         r_occ [NPOS];
  logic                  r_ovf;
  logic [NPOS-1:0]       r_ovf_mask;
  logic                  r_done;
  logic                  r_clr;

  logic                  w_abort;
  logic                  w_xfer;
  logic                  w_rd_go;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_occ_sum;
  logic [WW-1:0]         w_head;

`ifdef PIC_LOAD_ABORT_EN
  logic                  r_aborted;
  assign w_abort = abort && ((r_state == ST_CLEAR) || (r_state == ST_STREAM) ||
                             (r_state == ST_DRAIN));
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // Read data arriving this cycle bypasses the empty buffer so the first word
  // is presented in the cycle it returns from memory.
  assign w_valid   = (r_cnt != 2'd0) || r_inflight;
  assign w_head    = (r_cnt != 2'd0) ? r_fifo[r_rptr] : (r_inflight ? rd_data : '0);
  assign w_xfer    = w_valid && w_ready;
  assign w_push    = r_inflight && !((r_cnt == 2'd0) && w_xfer);
  assign w_pop     = w_xfer && (r_cnt != 2'd0);
  assign w_occ_sum = {1'b0, r_cnt} + {2'b00, r_inflight};

  // Never more than two words buffered or in flight once this cycle's pop is counted.
  assign w_rd_go   = (r_state == ST_STREAM) && (r_n < KL) &&
                     (w_occ_sum < (3'd2 + {2'b00, w_xfer}));

  assign rd_en     = w_rd_go;
  assign rd_addr   = w_rd_go ? (r_base + ADDR_WIDTH'(r_n)) : '0;
  assign w_data    = w_head;
  assign w_kidx    = w_valid ? r_kidx : 8'd0;
  assign w_last    = w_valid && (r_kidx == KL);

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign conv_clr  = r_clr;
  assign ovf       = r_ovf;
  assign ovf_mask  = r_ovf_mask;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_n        <= 8'd0;
      r_kidx     <= 8'd0;
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_cnt      <= 2'd0;
      r_ovf      <= 1'b0;
      r_ovf_mask <= '0;
      r_done     <= 1'b0;
      r_clr      <= 1'b0;
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      for (int p = 0; p < NPOS; p++) r_occ[p] <= '0;
`ifdef PIC_LOAD_ABORT_EN
      r_aborted  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_clr  <= 1'b0;
`ifdef PIC_LOAD_ABORT_EN
      r_aborted <= 1'b0;
`endif

      if (w_abort) begin
        r_inflight <= 1'b0;
        r_cnt      <= 2'd0;
        r_wptr     <= 1'b0;
        r_rptr     <= 1'b0;
      end else begin
        r_inflight <= w_rd_go;
        if (w_push) begin
          r_fifo[r_wptr] <= rd_data;
          r_wptr         <= ~r_wptr;
        end
        if (w_pop) r_rptr <= ~r_rptr;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end

      if (w_xfer) begin
        r_kidx <= r_kidx + 8'd1;
        for (int p = 0; p < NPOS; p++) begin
          if (w_head[p*DATA_WIDTH +: DATA_WIDTH] != '0) begin
            if (r_occ[p] < CW'(S)) begin
              r_occ[p] <= r_occ[p] + CW'(1);
            end else begin
              r_ovf_mask[p] <= 1'b1;
              r_ovf         <= 1'b1;
            end
          end
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base  <= base_addr;
            r_clr   <= 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_n        <= 8'd0;
          r_kidx     <= 8'd1;
          r_ovf      <= 1'b0;
          r_ovf_mask <= '0;
          for (int p = 0; p < NPOS; p++) r_occ[p] <= '0;
          r_state    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_rd_go) begin
            r_n <= r_n + 8'd1;
            if (r_n == KL - 8'd1) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((r_cnt == 2'd0) && !r_inflight) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_abort) begin
        r_state <= ST_IDLE;
        r_done  <= 1'b0;
`ifdef PIC_LOAD_ABORT_EN
        r_aborted <= 1'b1;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pic_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_load_ctrl
// Brief    : Scoreboard bench for pic_load_ctrl with a behavioural memory and
//            occupancy model; abort scenario built when PIC_LOAD_ABORT_EN is set.
// Revision : 1.0  initial release
// ============================================================================
module tb_pic_load_ctrl;
  localparam int DW   = 8;
  localparam int K    = 10;
  localparam int S    = 3;
  localparam int KH   = 3;
  localparam int KW   = 3;
  localparam int AW   = 8;
  localparam int NPOS = KH * KW;
  localparam int WW   = NPOS * DW;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic            busy, done, conv_clr, rd_en;
  logic [AW-1:0]   rd_addr;
  logic [WW-1:0]   rd_data;
  logic            w_valid;
  logic            w_ready;
  logic [WW-1:0]   w_data;
  logic [7:0]      w_kidx;
  logic            w_last;
  logic            ovf;
  logic [NPOS-1:0] ovf_mask;
`ifdef PIC_LOAD_ABORT_EN
  logic            abort;
  logic            aborted;
`endif

  pic_load_ctrl #(
    .DATA_WIDTH(DW), .K(K), .S(S), .KH(KH), .KW(KW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .base_addr(base_addr),
`ifdef PIC_LOAD_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .conv_clr(conv_clr), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_kidx(w_kidx), .w_last(w_last), .ovf(ovf),
    .ovf_mask(ovf_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] data;
    logic [7:0]    kidx;
    logic          last;
  } exp_t;

  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  logic [WW-1:0]   mem [256];
  exp_t            q[$];
  int              ready_mode = 0;
  logic [AW-1:0]   job_base = '0;
  int              rd_issued = 0;
  int              xfers = 0;
  int              first_x = -1;
  int              last_x = -1;
  int              t0 = 0;
  int              nz_cnt [NPOS];
  logic [NPOS-1:0] exp_mask = '0;
  bit              ovf_guard = 1'b1;
  bit              stalled = 1'b0;
  logic [WW-1:0]   held_data;
  logic [7:0]      held_kidx;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < NPOS; p++) nz_cnt[p] = 0;
    exp_mask = '0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: data valid exactly one cycle after rd_en, garbage otherwise.
  initial begin
    logic          pend;
    logic [AW-1:0] paddr;
    logic [95:0]   junk;
    rd_data = '0;
    forever begin
      @(negedge clk);
      pend  = rd_en;
      paddr = rd_addr;
      @(posedge clk);
      #1;
      junk    = {$urandom(), $urandom(), $urandom()};
      rd_data = pend ? mem[paddr] : junk[WW-1:0];
    end
  end

  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ~w_ready;
        default: w_ready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks side outputs.
  initial begin
    exp_t          e;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        stalled = 1'b0;
        continue;
      end
      if (!ovf_guard) begin
        chk("ovf_mask", ovf_mask, exp_mask);
        chk("ovf", ovf, |exp_mask);
      end
      if (stalled) begin
        chk("stall_valid", w_valid, 1'b1);
        chk("stall_data", w_data, held_data);
        chk("stall_kidx", w_kidx, held_kidx);
      end
      if (w_valid && w_ready) begin
        xfers++;
        if (first_x < 0) first_x = cyc - t0;
        last_x = cyc - t0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual kidx=%0d required none", w_kidx);
        end else begin
          e = q.pop_front();
          chk("w_data", w_data, e.data);
          chk("w_kidx", w_kidx, e.kidx);
          chk("w_last", w_last, e.last);
          for (int p = 0; p < NPOS; p++) begin
            if (e.data[p*DW +: DW] != '0) begin
              nz_cnt[p]++;
              if (nz_cnt[p] > S) exp_mask[p] = 1'b1;
            end
          end
        end
      end
      if (rd_en) begin
        ea = job_base + rd_issued[AW-1:0];
        chk("rd_addr", rd_addr, ea);
        rd_issued++;
        chk("rd_count_le_K", rd_issued <= K, 1'b1);
        chk("rd_outstanding_le2", (rd_issued - xfers) <= 2, 1'b1);
      end
      if (done) chk("done_premature_q", q.size(), 0);
      stalled   = w_valid && !w_ready;
      held_data = w_data;
      held_kidx = w_kidx;
    end
  end

  task automatic run_job(input logic [AW-1:0] base, input int mode);
    logic [AW-1:0] a;
    exp_t          e;
    @(negedge clk);
    ready_mode = mode;
    job_base   = base;
    rd_issued  = 0;
    xfers      = 0;
    first_x    = -1;
    last_x     = -1;
    for (int k = 0; k < K; k++) begin
      a      = base + AW'(k);
      e.data = mem[a];
      e.kidx = 8'(k + 1);
      e.last = (k == K - 1);
      q.push_back(e);
    end
    start     = 1'b1;
    base_addr = base;
    t0        = cyc;
    ovf_guard = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("conv_clr_in_clear", conv_clr, 1'b1);
    chk("busy_in_clear", busy, 1'b1);
    @(posedge clk);
    #1;
    chk("conv_clr_single", conv_clr, 1'b0);
    chk("ovf_cleared_by_clear", {ovf, ovf_mask}, '0);
    model_clear();
    ovf_guard = 1'b0;
  endtask

  task automatic wait_done(input bit timed);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1'b1);
    if (got) begin
      chk("done_q_empty", q.size(), 0);
      chk("reads_issued", rd_issued, K);
      if (timed) begin
        chk("done_latency", cyc - t0, K + 4);
        chk("first_valid_cycle", first_x, 3);
        chk("last_xfer_cycle", last_x, K + 2);
      end
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("idle_not_busy", busy, 1'b0);
    end
  endtask

  initial begin
    bit         saw;
    bit         got;
    int         mode;
    logic [7:0] b;
    for (int a = 0; a < 256; a++)
      for (int p = 0; p < NPOS; p++)
        mem[a][p*DW +: DW] = ($urandom_range(0, 99) < 35) ? 8'($urandom_range(1, 255)) : 8'd0;
    model_clear();
    rst_b     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
`ifdef PIC_LOAD_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, conv_clr, rd_en, rd_addr, w_valid, w_data,
                          w_kidx, w_last, ovf, ovf_mask}, '0);
    @(negedge clk);
    rst_b = 1'b1;

    // Basic job, all weights 1, full throughput.
    for (int a = 8'h10; a < 8'h1A; a++) mem[a] = {NPOS{8'h01}};
    run_job(8'h10, 0);
    wait_done(1'b1);

    // Backpressure with alternating ready.
    run_job(8'h30, 1);
    wait_done(1'b0);

    // Overflow: only lane 4 populated, in kernels 1..4.
    for (int k = 0; k < K; k++) mem[8'h40 + k] = '0;
    for (int k = 0; k < 4; k++) mem[8'h40 + k][4*DW +: DW] = 8'(8'h51 + k);
    run_job(8'h40, 0);
    wait_done(1'b1);
    chk("ovf_mask_after_done", ovf_mask, 9'b000010000);
    chk("ovf_after_done", ovf, 1'b1);
    repeat (3) @(negedge clk);
    chk("ovf_held_in_idle", {ovf, ovf_mask}, {1'b1, 9'b000010000});

    // Address wrap at the top of memory.
    run_job(8'hFC, 0);
    wait_done(1'b1);

    // Reset in the middle of streaming.
    run_job(8'h60, 0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (xfers >= 5) got = 1'b1;
    end
    chk("reached_kidx5", got, 1'b1);
    @(posedge clk);
    #2;
    rst_b     = 1'b0;
    ovf_guard = 1'b1;
    #1;
    chk("midjob_reset_outputs", {busy, done, conv_clr, rd_en, rd_addr, w_valid, w_data,
                                 w_kidx, w_last, ovf, ovf_mask}, '0);
    q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("no_done_after_reset", saw, 1'b0);
    run_job(8'h60, 0);
    wait_done(1'b1);

`ifdef PIC_LOAD_ABORT_EN
    // Abort while word 3 is stalled.
    run_job(8'h80, 1);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (w_valid && !w_ready && (w_kidx == 8'd3)) got = 1'b1;
    end
    chk("abort_point_reached", got, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort   = 1'b0;
    stalled = 1'b0;
    chk("aborted_pulse", aborted, 1'b1);
    chk("abort_to_idle", busy, 1'b0);
    chk("abort_flush", w_valid, 1'b0);
    chk("abort_no_done", done, 1'b0);
    q.delete();
    @(negedge clk);
    chk("aborted_one_cycle", aborted, 1'b0);
    chk("abort_no_stale_word", w_valid, 1'b0);
    run_job(8'h80, 0);
    wait_done(1'b1);
`endif

    // Randomized jobs over random memory and ready patterns.
    for (int j = 0; j < 8; j++) begin
      b    = 8'($urandom_range(0, 255));
      mode = j % 3;
      run_job(b, mode);
      wait_done(mode == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pic_load_ctrl.md
Name: pic_load_ctrl

Overview:
- Sequencer in front of the pattern-to-index/compressed converter.
- On a start command it clears the converter, then fetches K dense kernel words (KH*KW weights each) from weight memory and streams them one per accepted handshake with a 1-based kernel index.
- Tracks per-position non-zero occupancy and flags positions that exceed the S compressed slots.
- Full throughput: one word per cycle when the sink is always ready.

Parameters:
DATA_WIDTH, 8, weight width
K, 10, kernels per job
S, 3, compressed slots per kernel position
KH, 3, kernel height
KW, 3, kernel width (NPOS = KH*KW)
ADDR_WIDTH, 8, weight memory address width

Ports:
clk  in  1  clock, all logic on rising edge
rst_b  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
base_addr  in  ADDR_WIDTH  address of kernel 1; captured on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end
conv_clr  out  1  one-cycle converter clear pulse
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_WIDTH  read address
rd_data  in  NPOS*DATA_WIDTH  read data, valid exactly one cycle after rd_en; lane p = bits [p*DW +: DW]
w_valid  out  1  word available
w_ready  in  1  sink accepts word
w_data  out  NPOS*DATA_WIDTH  kernel weights
w_kidx  out  8  kernel index, 1..K
w_last  out  1  high with the word whose w_kidx==K
ovf  out  1  sticky slot-overflow flag
ovf_mask  out  NPOS  per-position overflow bits

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; buffer empty; counters 0.
- Transfer = w_valid && w_ready, counted at the rising edge.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: on start=1, capture base_addr, go to CLEAR.
- CLEAR (1 cycle):
  - conv_clr=1.
  - Issue counter n=0, index counter=1, occupancy counters=0, ovf=0, ovf_mask=0.
  - Next state STREAM.
- STREAM:
  - rd_en=1 when n<K and (buffered words + reads in flight − transfer this cycle) < 2.
  - rd_addr = base_addr + n, wrapping modulo 2^ADDR_WIDTH; n increments on each issue.
  - When n reaches K, go to DRAIN.
- Output buffer:
  - 2-entry FIFO holding rd_data, written in the cycle after rd_en.
  - Head drives w_data, w_kidx, w_last; w_valid = FIFO not empty.
  - Data and index are held stable while w_valid && !w_ready.
  - FIFO never overflows; a simultaneous write and pop is legal.
- DRAIN: wait until FIFO empty and no read in flight, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored.
- Latency with w_ready held high: start at cycle 0, CLEAR at cycle 1, first rd_en at cycle 2, first w_valid at cycle 3, last transfer at cycle K+2, done at cycle K+4.
- Occupancy, on each transfer for every lane p with a non-zero value:
  - If cnt[p] < S, cnt[p] increments.
  - Otherwise cnt[p] holds at S, ovf_mask[p]=1 and ovf=1.
  - The word is still transferred unchanged.
  - ovf and ovf_mask hold through IDLE; only the next CLEAR clears them.
- K counts up to 255; w_kidx width is fixed at 8 and K≤255 is required.
- Reset mid-job: immediate return to IDLE; in-flight read data is discarded and no done pulse is produced.

Optional Feature:
Macro PIC_LOAD_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in CLEAR, STREAM or DRAIN: next state IDLE, FIFO flushed, rd_data arriving next cycle ignored.
  - aborted=1 for one cycle; done not pulsed; ovf and ovf_mask retained.
  - abort in IDLE or DONE has no effect.
- Not defined: ports absent; behaviour as above.

Test Plan:
- Basic job, w_ready=1, base_addr=0x10, K=10, all weights 1 → conv_clr at cycle 1; rd_addr 0x10..0x19; w_kidx 1..10 on consecutive cycles; w_last only with kidx 10; done at cycle 14; ovf=0.
- Backpressure, w_ready toggling 1,0,1,0 → no word lost or duplicated; w_data stable while stalled; at most 2 outstanding reads; done after 10 transfers.
- Overflow: lane 4 non-zero in kernels 1-4, all other lanes zero → ovf=1 and ovf_mask=9'b000010000 set at the kernel-4 transfer; still set after done; cleared at the next job's CLEAR.
- Address wrap: base_addr=0xFC, K=10 → rd_addr 0xFC..0xFF, then 0x00..0x05.
- Reset: rst_b=0 during STREAM after kidx 5 → all outputs 0 immediately, no done; next start runs a full job from kidx 1.
- PIC_LOAD_ABORT_EN: abort at kidx 3 under stall → aborted pulse, no done, IDLE next cycle, stale rd_data not presented on the following job.
